// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds opcode constants, the controller state encoding and the datapath
// mux/ALU select encodings used by the FSM and the ALU function decoder.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC,
    S_LUI, S_AUIPC, S_HALT
  } state_t;

  // ALU operation class selected by the FSM
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// ALU function decoder: maps aluOp plus func3/func7 to an ALU control code.
// Ports: aluOp/op/func3/func7 in; aluControl out; illegal flags an R/I-type
// encoding the core cannot execute (bad func7, or shifts when disabled).
module alu_decoder #(
  parameter bit EN_SHIFT = 1'b1
) (
  input  logic [1:0] aluOp,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [3:0] aluControl,
  output logic       illegal
);
  import riscv_pkg::*;

  logic is_r;
  logic is_shift;
  logic f7_ok;

  always_comb begin
    is_r     = (op == OP_R);
    is_shift = (func3 == 3'b001) || (func3 == 3'b101);
    f7_ok    = (func7 == 7'b0000000) || (func7 == 7'b0100000);

    // Legality is judged from the instruction alone so DECODE can use it
    // while the ALU is still busy with the target add.
    illegal = 1'b0;
    if (is_r && !f7_ok) illegal = 1'b1;
    if ((is_r || op == OP_I) && is_shift && (!EN_SHIFT || !f7_ok)) illegal = 1'b1;

    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3)
          3'b000:  aluControl = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl = ALU_SLL;
          3'b010:  aluControl = ALU_SLT;
          3'b011:  aluControl = ALU_SLTU;
          3'b100:  aluControl = ALU_XOR;
          3'b101:  aluControl = func7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  aluControl = ALU_OR;
          default: aluControl = ALU_AND;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects and register/memory enables.
// Ports: op/func3/func7 from IR, ALU flags, memReady in; datapath controls and
// sticky done out. All outputs read 0 while rst_n is low.
module multicycle_controller #(
  parameter bit EN_SHIFT   = 1'b1,
  parameter bit EN_UBRANCH = 1'b1,
  parameter bit EN_AUIPC   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       adrSrc,
  output logic       memRead,
  output logic       memWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [3:0] aluControl,
  output logic [1:0] resultSrc,
  output logic [2:0] immSrc,
  output logic       regWrite,
  output logic       done
);
  import riscv_pkg::*;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic [3:0] dec_ctl;
  logic       dec_illegal;
  logic       taken;
  logic       br_illegal;

  alu_decoder #(.EN_SHIFT(EN_SHIFT)) u_alu_dec (
    .aluOp      (alu_op),
    .op         (op),
    .func3      (func3),
    .func7      (func7),
    .aluControl (dec_ctl),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Kept apart from the main decode so the decoder output never feeds back
  // into the block that selects its operation.
  always_comb begin
    alu_op = ALUOP_ADD;
    if (state_q == S_EXECR || state_q == S_EXECI) alu_op = ALUOP_FUNC;
    else if (state_q == S_BRANCH)                 alu_op = ALUOP_SUB;
  end

  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
    br_illegal = (func3[2:1] == 2'b01) || (!EN_UBRANCH && func3[2:1] == 2'b11);
  end

  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    adrSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RS2;
    resultSrc = RES_ALUOUT;
    immSrc    = IMM_I;
    regWrite  = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        irWrite   = memReady;
        pcWrite   = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jal target into aluOut
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:      state_d = dec_illegal ? S_HALT : S_EXECR;
          OP_I:      state_d = dec_illegal ? S_HALT : S_EXECI;
          OP_BRANCH: state_d = br_illegal ? S_HALT : S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = EN_AUIPC ? S_AUIPC : S_HALT;
          default:   state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        immSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        memRead = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = SRCA_RS1;
        pcWrite = taken;
        state_d = S_FETCH;
      end
      S_JAL, S_JALRPC: begin
        // PC takes the target in aluOut while the ALU forms the link oldPC+4
        pcWrite = 1'b1;
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = S_JALRPC;
      end
      S_LUI: begin
        aluSrcA = SRCA_ZERO;
        aluSrcB = SRCB_IMM;
        immSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        immSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      default: begin
        done    = 1'b1;
        state_d = S_HALT;
      end
    endcase

    if (!rst_n) begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      adrSrc    = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      resultSrc = 2'b00;
      immSrc    = 3'b000;
      regWrite  = 1'b0;
      done      = 1'b0;
    end
  end

  assign aluControl = rst_n ? dec_ctl : 4'b0000;

endmodule
